// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store requests onto a byte-wide RAM/IO bus.
//  clk_in/rst_n_in/rdy_in/clr_in : clock, async active-low reset, global enable, flush
//  if_to_mc_* / mc_to_if_*       : fetch request (level) and one-cycle done pulse with word
//  lsb_to_mc_* / mc_to_lsb_*     : load/store request (level) and one-cycle done pulse with data
//  mem_din/mem_dout/mem_a/mem_wr : byte-wide RAM/IO bus; io_buffer_full stalls IO stores
module mem_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = 32'h30000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic                  if_to_mc_ready,
    input  logic [ADDR_WIDTH-1:0] if_to_mc_PC,
    output logic                  mc_to_if_ready,
    output logic [31:0]           mc_to_if_inst,
    input  logic                  lsb_to_mc_valid,
    input  logic                  lsb_to_mc_wr,
    input  logic [ADDR_WIDTH-1:0] lsb_to_mc_addr,
    input  logic [1:0]            lsb_to_mc_len,
    input  logic [31:0]           lsb_to_mc_data,
    output logic                  mc_to_lsb_ready,
    output logic [31:0]           mc_to_lsb_data,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_a_q, mem_a_d, nxt_a;
    logic [1:0]  nl_q, nl_d, cnt_q, cnt_d, cnt_inc, lsb_nl;
    logic [31:0] data_q, data_d, buf_q, buf_d, inst_q, inst_d, ldata_q, ldata_d, asm_w;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d, if_rdy_q, if_rdy_d, lsb_rdy_q, lsb_rdy_d;
    logic        acc_lsb, acc_if, stall_acc, stall_cur, stall_nxt, last;
    // nl = index of the final byte of the access (N-1); len 3 behaves as a word
    assign lsb_nl    = lsb_to_mc_len == 2'd0 ? 2'd0 : lsb_to_mc_len == 2'd1 ? 2'd1 : 2'd3;
    // a port whose done pulse is currently high is not taken again this edge
    assign acc_lsb   = state_q == IDLE && !clr_in && lsb_to_mc_valid && !lsb_rdy_q;
    assign acc_if    = state_q == IDLE && !clr_in && if_to_mc_ready && !if_rdy_q && !acc_lsb;
    assign cnt_inc   = cnt_q + 2'd1;
    assign nxt_a     = addr_q + ADDR_WIDTH'(cnt_inc);
    assign last      = cnt_q == nl_q;
    assign stall_acc = io_buffer_full && lsb_to_mc_addr >= IO_ADDR_BASE;
    assign stall_cur = io_buffer_full && mem_a_q >= IO_ADDR_BASE;
    assign stall_nxt = io_buffer_full && nxt_a >= IO_ADDR_BASE;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else if (rdy_in) state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = acc_lsb ? (lsb_to_mc_wr ? STORE : LOAD) : acc_if ? IFETCH : IDLE;
            IFETCH, LOAD: state_d = (clr_in || last) ? IDLE : state_q;
            STORE:        state_d = (wr_q && last) ? IDLE : STORE;
            default:      state_d = IDLE;
        endcase
    end
    // byte cnt of the access is merged into the partially assembled word
    always_comb begin
        asm_w = buf_q;
        asm_w[{cnt_q, 3'b000} +: 8] = mem_din;
    end
    always_comb begin
        addr_d    = addr_q;
        nl_d      = nl_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        mem_a_d   = mem_a_q;
        dout_d    = dout_q;
        wr_d      = wr_q;
        if_rdy_d  = 1'b0;
        lsb_rdy_d = 1'b0;
        inst_d    = inst_q;
        ldata_d   = ldata_q;
        case (state_q)
            IDLE: begin
                if (acc_lsb) begin
                    addr_d  = lsb_to_mc_addr;
                    nl_d    = lsb_nl;
                    data_d  = lsb_to_mc_data;
                    cnt_d   = 2'd0;
                    buf_d   = 32'd0;
                    mem_a_d = lsb_to_mc_addr;
                    if (lsb_to_mc_wr) begin
                        dout_d = lsb_to_mc_data[7:0];
                        wr_d   = !stall_acc;
                    end
                end else if (acc_if) begin
                    addr_d  = if_to_mc_PC;
                    nl_d    = 2'd3;
                    cnt_d   = 2'd0;
                    buf_d   = 32'd0;
                    mem_a_d = if_to_mc_PC;
                end
            end
            IFETCH, LOAD: begin
                if (clr_in) begin
                    mem_a_d = '0;
                end else if (last) begin
                    mem_a_d = '0;
                    if (state_q == IFETCH) begin
                        if_rdy_d = 1'b1;
                        inst_d   = asm_w;
                    end else begin
                        lsb_rdy_d = 1'b1;
                        ldata_d   = asm_w;
                    end
                end else begin
                    buf_d   = asm_w;
                    cnt_d   = cnt_inc;
                    mem_a_d = nxt_a;
                end
            end
            STORE: begin
                // wr_q low means the byte at mem_a is still waiting on the IO buffer
                if (!wr_q) begin
                    wr_d = !stall_cur;
                end else if (last) begin
                    wr_d      = 1'b0;
                    lsb_rdy_d = 1'b1;
                    mem_a_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                    mem_a_d = nxt_a;
                    dout_d  = data_q[{cnt_inc, 3'b000} +: 8];
                    wr_d    = !stall_nxt;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q    <= '0;
            nl_q      <= 2'd0;
            data_q    <= 32'd0;
            cnt_q     <= 2'd0;
            buf_q     <= 32'd0;
            mem_a_q   <= '0;
            dout_q    <= 8'd0;
            wr_q      <= 1'b0;
            if_rdy_q  <= 1'b0;
            lsb_rdy_q <= 1'b0;
            inst_q    <= 32'd0;
            ldata_q   <= 32'd0;
        end else if (rdy_in) begin
            addr_q    <= addr_d;
            nl_q      <= nl_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            mem_a_q   <= mem_a_d;
            dout_q    <= dout_d;
            wr_q      <= wr_d;
            if_rdy_q  <= if_rdy_d;
            lsb_rdy_q <= lsb_rdy_d;
            inst_q    <= inst_d;
            ldata_q   <= ldata_d;
        end
    end
    assign mem_a           = mem_a_q;
    assign mem_dout        = dout_q;
    assign mem_wr          = wr_q && rdy_in;
    assign mc_to_if_ready  = if_rdy_q;
    assign mc_to_if_inst   = inst_q;
    assign mc_to_lsb_ready = lsb_rdy_q;
    assign mc_to_lsb_data  = ldata_q;
endmodule
